// File: rtl/selevy_ram_arb_pkg.sv
// Shared types and defaults for the selevy RAM arbiter.
`default_nettype none

package selevy_ram_arb_pkg;

   localparam int RAM_ADDR_W = 8;
   localparam int RAM_DATA_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_C = 1'b0,
      PORT_L = 1'b1
   } port_e;

endpackage

`default_nettype wire

// File: rtl/selevy_ram_arb_if.sv
// Requester and RAM-side bus of the selevy RAM arbiter.
`default_nettype none

interface selevy_ram_arb_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4
);
   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_ack;
   logic [DATA_W-1:0] c_rdata;
   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_ack;
   logic [DATA_W-1:0] l_rdata;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;
   logic              busy;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, ram_rdata,
      output c_ack, c_rdata, l_ack, l_rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, ram_rdata,
      input  c_ack, c_rdata, l_ack, l_rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

`default_nettype wire

// File: rtl/selevy_ram_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to the port not granted last.
`default_nettype none

module selevy_rr_pick
   import selevy_ram_arb_pkg::*;
(
   input  logic [1:0] reqs,
   input  port_e      last_grant,
   output port_e      grant,
   output logic       valid
);

   always_comb begin
      valid = |reqs;
      grant = PORT_C;
      if (reqs == 2'b11) begin
         grant = (last_grant == PORT_C) ? PORT_L : PORT_C;
      end else if (reqs[1]) begin
         grant = PORT_L;
      end
   end

endmodule

`default_nettype wire

// File: rtl/selevy_ram_arb.sv
// Round-robin arbiter sharing one synchronous RAM between CPU (C) and loader (L) ports.
// Optional statistics counters are built when SELEVY_ARB_STATS_EN is defined.
`default_nettype none

module selevy_ram_arb
   import selevy_ram_arb_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
)
(
   input  logic CLK,
   input  logic reset,
   selevy_ram_arb_if.slave bus
`ifdef SELEVY_ARB_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [15:0] stat_conflict,
   output logic [15:0] stat_grants
`endif
);

   state_e            state_q, state_d;
   port_e             owner_q, owner_d;
   port_e             last_q, last_d;
   logic              op_we_q, op_we_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

   logic [1:0] reqs;
   logic       take;
   port_e      pick_grant;
   logic       pick_valid;

   // The current owner's request is masked during RESP so a held req cannot re-win immediately.
   always_comb begin
      reqs = {bus.l_req, bus.c_req};
      if (state_q == ST_RESP) begin
         if (owner_q == PORT_C) reqs[0] = 1'b0;
         else                   reqs[1] = 1'b0;
      end
   end

   selevy_rr_pick u_pick (
      .reqs       (reqs),
      .last_grant (last_q),
      .grant      (pick_grant),
      .valid      (pick_valid)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      op_we_d     = op_we_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_wdata_d = '0;
      take        = 1'b0;
      case (state_q)
         ST_IDLE:   take = pick_valid;
         ST_ACCESS: state_d = ST_RESP;
         ST_RESP: begin
            state_d = ST_IDLE;
            take    = pick_valid;
         end
         default:   state_d = ST_IDLE;
      endcase
      if (take) begin
         state_d  = ST_ACCESS;
         owner_d  = pick_grant;
         last_d   = pick_grant;
         ram_en_d = 1'b1;
         if (pick_grant == PORT_L) begin
            ram_we_d    = bus.l_we;
            ram_addr_d  = bus.l_addr;
            ram_wdata_d = bus.l_wdata;
         end else begin
            ram_we_d    = bus.c_we;
            ram_addr_d  = bus.c_addr;
            ram_wdata_d = bus.c_wdata;
         end
         op_we_d = ram_we_d;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= PORT_C;
         last_q      <= PORT_L;
         op_we_q     <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         op_we_q     <= op_we_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
      end
   end

   assign bus.ram_en    = ram_en_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.c_ack     = (state_q == ST_RESP) && (owner_q == PORT_C);
   assign bus.l_ack     = (state_q == ST_RESP) && (owner_q == PORT_L);
   assign bus.c_rdata   = (bus.c_ack && !op_we_q) ? bus.ram_rdata : '0;
   assign bus.l_rdata   = (bus.l_ack && !op_we_q) ? bus.ram_rdata : '0;

`ifdef SELEVY_ARB_STATS_EN
   logic [15:0] stat_conflict_q, stat_conflict_d;
   logic [15:0] stat_grants_q, stat_grants_d;

   always_comb begin
      stat_conflict_d = stat_conflict_q;
      stat_grants_d   = stat_grants_q;
      if (stat_clr) begin
         stat_conflict_d = '0;
         stat_grants_d   = '0;
      end else if (take) begin
         if (stat_grants_q != 16'hFFFF) stat_grants_d = stat_grants_q + 16'd1;
         if (reqs == 2'b11 && stat_conflict_q != 16'hFFFF)
            stat_conflict_d = stat_conflict_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         stat_conflict_q <= '0;
         stat_grants_q   <= '0;
      end else begin
         stat_conflict_q <= stat_conflict_d;
         stat_grants_q   <= stat_grants_d;
      end
   end

   assign stat_conflict = stat_conflict_q;
   assign stat_grants   = stat_grants_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_selevy_ram_arb.sv
// Directed bench for selevy_ram_arb with a behavioural synchronous RAM.
`default_nettype none

module tb_selevy_ram_arb;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   selevy_ram_arb_if #(.ADDR_W(8), .DATA_W(4)) bus ();

`ifdef SELEVY_ARB_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_conflict;
   logic [15:0] stat_grants;
`endif

   selevy_ram_arb dut (
      .CLK   (clk),
      .reset (rst_n),
      .bus   (bus)
`ifdef SELEVY_ARB_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_conflict (stat_conflict),
      .stat_grants   (stat_grants)
`endif
   );

   always #5 clk = ~clk;

   logic [3:0] mem [256];
   logic [3:0] ram_rd = 4'd0;

   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else            ram_rd <= mem[bus.ram_addr];
      end
   end
   assign bus.ram_rdata = ram_rd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One transaction on port (0 = C, 1 = L); expects ram_en after 1 cycle and ack after 2.
   task automatic access(input bit port, input bit we, input logic [7:0] addr,
                         input logic [3:0] wd, input logic [3:0] exp_rd, input string tag);
      bit got_ack;
      int lat;
      cyc();
      if (port) begin
         bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wd;
      end else begin
         bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
      end
      got_ack = 1'b0;
      lat = 0;
      for (int n = 0; n < 8 && !got_ack; n++) begin
         @(negedge clk);
         check({tag, "_excl"}, bus.c_ack & bus.l_ack, 0);
         if (n == 1) begin
            check({tag, "_en"}, bus.ram_en, 1);
            check({tag, "_addr"}, bus.ram_addr, addr);
            check({tag, "_we"}, bus.ram_we, we);
            if (we) check({tag, "_wdata"}, bus.ram_wdata, wd);
         end
         if (port ? bus.l_ack : bus.c_ack) begin
            got_ack = 1'b1;
            lat = n;
            check({tag, "_rdata"}, port ? bus.l_rdata : bus.c_rdata, we ? 4'd0 : exp_rd);
         end else begin
            @(posedge clk);
            #1;
         end
      end
      check({tag, "_ack_seen"}, got_ack, 1);
      check({tag, "_latency"}, lat, 2);
      cyc();
      if (port) bus.l_req = 1'b0;
      else      bus.c_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 4'd0;
      mem[3] = 4'b1010;
      mem[8] = 4'b0011;
      mem[9] = 4'b1100;
      bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
      bus.l_req = 0; bus.l_we = 0; bus.l_addr = 0; bus.l_wdata = 0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_ram_en", bus.ram_en, 0);
      check("rst_ram_we", bus.ram_we, 0);
      check("rst_ram_addr", bus.ram_addr, 0);
      check("rst_ram_wdata", bus.ram_wdata, 0);
      check("rst_c_ack", bus.c_ack, 0);
      check("rst_l_ack", bus.l_ack, 0);
      check("rst_c_rdata", bus.c_rdata, 0);
      check("rst_l_rdata", bus.l_rdata, 0);
      check("rst_busy", bus.busy, 0);
`ifdef SELEVY_ARB_STATS_EN
      check("rst_stat_conflict", stat_conflict, 0);
      check("rst_stat_grants", stat_grants, 0);
`endif
      cyc();
      rst_n = 1'b1;

      access(1'b0, 1'b0, 8'd3, 4'd0, 4'b1010, "c_read3");
      @(negedge clk);
      check("idle_c_rdata", bus.c_rdata, 0);
      check("idle_busy", bus.busy, 0);

      access(1'b1, 1'b1, 8'd5, 4'b0110, 4'd0, "l_write5");
      access(1'b0, 1'b0, 8'd5, 4'd0, 4'b0110, "c_read5");
      access(1'b1, 1'b0, 8'd3, 4'd0, 4'b1010, "l_read3");

      // Held CPU request: acks at cycles 2, 5, 8
      cyc();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'd3;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk);
         check($sformatf("held_c_ack_%0d", k), bus.c_ack, (k == 2 || k == 5 || k == 8));
         if (k == 3 || k == 6) check($sformatf("held_busy_%0d", k), bus.busy, 0);
         if (k == 8) check("held_rdata", bus.c_rdata, 4'b1010);
      end
      bus.c_req = 1'b0;
      cyc();

      // Asynchronous reset during ACCESS
      cyc();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'd3;
      @(negedge clk);
      @(negedge clk);
      check("midrst_en_before", bus.ram_en, 1);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_en_after", bus.ram_en, 0);
      check("midrst_busy", bus.busy, 0);
      bus.c_req = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      begin
         logic any_ack;
         any_ack = 1'b0;
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            any_ack = any_ack | bus.c_ack | bus.l_ack;
         end
         check("midrst_no_ack", any_ack, 0);
      end

      // Simultaneous saturating requests after reset: C first, then alternate
      cyc();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'd8;
      bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'd9;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         if (k >= 1) begin
            check($sformatf("rr_excl_%0d", k), bus.c_ack & bus.l_ack, 0);
            if (k % 2 == 1) begin
               check($sformatf("rr_en_%0d", k), bus.ram_en, 1);
               check($sformatf("rr_addr_%0d", k), bus.ram_addr,
                     (((k + 1) / 2) % 2 == 1) ? 8'd8 : 8'd9);
            end else begin
               check($sformatf("rr_c_ack_%0d", k), bus.c_ack, ((k / 2) % 2 == 1));
               check($sformatf("rr_l_ack_%0d", k), bus.l_ack, ((k / 2) % 2 == 0));
               if ((k / 2) % 2 == 1) check($sformatf("rr_c_rd_%0d", k), bus.c_rdata, 4'b0011);
               else                  check($sformatf("rr_l_rd_%0d", k), bus.l_rdata, 4'b1100);
            end
         end
      end
      bus.c_req = 1'b0;
      bus.l_req = 1'b0;
      cyc();
      cyc();

`ifdef SELEVY_ARB_STATS_EN
      cyc();
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      @(negedge clk);
      check("stat_clr_conflict", stat_conflict, 0);
      check("stat_clr_grants", stat_grants, 0);
      // Four contended rounds (two grants each) plus two single accesses
      for (int r = 0; r < 4; r++) begin
         bit c_won;
         cyc();
         bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 8'd8;
         bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 8'd9;
         @(negedge clk);
         @(negedge clk);
         @(negedge clk);
         c_won = bus.c_ack;
         cyc();
         if (c_won) bus.c_req = 1'b0;
         else       bus.l_req = 1'b0;
         cyc();
         @(negedge clk);
         check($sformatf("stat_round_ack_%0d", r), bus.c_ack | bus.l_ack, 1);
         cyc();
         bus.c_req = 1'b0;
         bus.l_req = 1'b0;
      end
      access(1'b0, 1'b0, 8'd3, 4'd0, 4'b1010, "stat_c");
      access(1'b1, 1'b0, 8'd3, 4'd0, 4'b1010, "stat_l");
      @(negedge clk);
      check("stat_conflict_4", stat_conflict, 4);
      check("stat_grants_10", stat_grants, 10);
      cyc();
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      @(negedge clk);
      check("stat_clr2_conflict", stat_conflict, 0);
      check("stat_clr2_grants", stat_grants, 0);
      cyc();
      force dut.stat_grants_q = 16'hFFFF;
      #1 release dut.stat_grants_q;
      access(1'b0, 1'b0, 8'd3, 4'd0, 4'b1010, "stat_sat");
      @(negedge clk);
      check("stat_grants_sat", stat_grants, 16'hFFFF);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
